// File: rtl/cpu_pkg.sv
// Shared CPU definitions: controller states, opcodes, ALU codes, instruction classes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_SUB = 5'b00100;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  typedef enum logic [3:0] {
    C_NOP, C_ALU, C_ADDI, C_LDI, C_LD, C_ST, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT
  } iclass_t;

  typedef struct packed {
    logic       run;
    logic       pc_out, pc_in, pc_inc;
    logic       mar_in, mdr_in, mdr_out, read, write;
    logic       ir_in, y_in, z_in, zhi_out, zlo_out;
    logic       hi_in, hi_out, lo_in, lo_out;
    logic       gra, grb, grc, r_in, r_out, ba_out, c_out;
    logic       con_in, out_portin, in_portout;
    logic [4:0] alu;
  } ctrl_t;

  // Final execute step of each class; the step after it is T0 (or HALT on Stop).
  function automatic state_t last_step(input iclass_t c);
    case (c)
      C_JAL:                 last_step = S_T4;
      C_ALU, C_ADDI, C_LDI:  last_step = S_T5;
      C_BR:                  last_step = S_T6;
      C_LD, C_ST:            last_step = S_T7;
      default:               last_step = S_T3;
    endcase
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Maps the 5-bit opcode to an instruction class; unknown codes become nop.
// Latency: combinational.
// Backpressure: none.
module cu_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output iclass_t    iclass
);

  always_comb begin
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: iclass = C_ALU;
      OP_ADDI:                       iclass = C_ADDI;
      OP_LDI:                        iclass = C_LDI;
      OP_LD:                         iclass = C_LD;
      OP_ST:                         iclass = C_ST;
      OP_BR:                         iclass = C_BR;
      OP_JR:                         iclass = C_JR;
      OP_JAL:                        iclass = C_JAL;
      OP_IN:                         iclass = C_IN;
      OP_OUT:                        iclass = C_OUT;
      OP_MFHI:                       iclass = C_MFHI;
      OP_MFLO:                       iclass = C_MFLO;
      OP_HALT:                       iclass = C_HALT;
      default:                       iclass = C_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore microcode sequencer: fetch T0-T2, class-specific execute T3-T7, RESET/HALT idle states.
// Latency: one step per clock; 4 to 8 clocks per instruction depending on class.
// Backpressure: none; Stop is honoured only on an instruction's final step.
module control_unit
  import cpu_pkg::*;
(
  input  logic        Clock,
  input  logic        GlobalReset,
  input  logic [31:0] IR,
  input  logic        CONout,
  input  logic        Stop,
  output logic        Run,
  output logic        PCout, PCin, PCinc,
  output logic        MARin, MDRin, MDRout, Read, write,
  output logic        IRin, Yin, Zin, Zhiout, Zloout,
  output logic        HIin, HIout, LOin, LOout,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout,
  output logic        CONin, OUT_portin, IN_portout,
  output logic [4:0]  ALUControl
);

  state_t  state_q, state_d;
  iclass_t iclass;
  ctrl_t   c;
  logic    ir_unused;

  assign ir_unused = ^IR[26:0];

  cu_decode u_decode (
    .opcode (IR[31:27]),
    .iclass (iclass)
  );

  always_ff @(posedge Clock) begin
    if (GlobalReset) state_q <= S_RESET;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (state_q == S_T3 && iclass == C_HALT)
          state_d = S_HALT;
        else if (state_q >= last_step(iclass))
          state_d = Stop ? S_HALT : S_T0;
        else
          state_d = state_t'(state_q + 4'd1);
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    c     = '0;
    c.run = (state_q != S_RESET) && (state_q != S_HALT);
    case (state_q)
      S_T0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.pc_inc = 1'b1; end
      S_T1: begin c.read = 1'b1; c.mdr_in = 1'b1; end
      S_T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
      S_T3: begin
        case (iclass)
          C_ALU, C_ADDI:     begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
          C_LDI, C_LD, C_ST: begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
          C_BR:   begin c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; end
          C_JR:   begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
          C_JAL:  begin c.pc_out = 1'b1; c.grb = 1'b1; c.r_in = 1'b1; end
          C_IN:   begin c.in_portout = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          C_OUT:  begin c.gra = 1'b1; c.r_out = 1'b1; c.out_portin = 1'b1; end
          C_MFHI: begin c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          C_MFLO: begin c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (iclass)
          // For register ALU ops the opcode doubles as the ALU operation code.
          C_ALU: begin c.grc = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; c.alu = IR[31:27]; end
          C_ADDI, C_LDI, C_LD, C_ST: begin c.c_out = 1'b1; c.z_in = 1'b1; c.alu = ALU_ADD; end
          C_BR:  begin c.pc_out = 1'b1; c.y_in = 1'b1; end
          C_JAL: begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (iclass)
          C_ALU, C_ADDI, C_LDI: begin c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          C_LD, C_ST: begin c.zlo_out = 1'b1; c.mar_in = 1'b1; end
          C_BR:       begin c.c_out = 1'b1; c.z_in = 1'b1; c.alu = ALU_ADD; end
          default: ;
        endcase
      end
      S_T6: begin
        case (iclass)
          C_LD: begin c.read = 1'b1; c.mdr_in = 1'b1; end
          C_ST: begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1; end
          C_BR: begin c.zlo_out = CONout; c.pc_in = CONout; end
          default: ;
        endcase
      end
      S_T7: begin
        case (iclass)
          C_LD: begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          C_ST: c.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign Run        = c.run;
  assign PCout      = c.pc_out;
  assign PCin       = c.pc_in;
  assign PCinc      = c.pc_inc;
  assign MARin      = c.mar_in;
  assign MDRin      = c.mdr_in;
  assign MDRout     = c.mdr_out;
  assign Read       = c.read;
  assign write      = c.write;
  assign IRin       = c.ir_in;
  assign Yin        = c.y_in;
  assign Zin        = c.z_in;
  assign Zhiout     = c.zhi_out;
  assign Zloout     = c.zlo_out;
  assign HIin       = c.hi_in;
  assign HIout      = c.hi_out;
  assign LOin       = c.lo_in;
  assign LOout      = c.lo_out;
  assign Gra        = c.gra;
  assign Grb        = c.grb;
  assign Grc        = c.grc;
  assign Rin        = c.r_in;
  assign Rout       = c.r_out;
  assign BAout      = c.ba_out;
  assign Cout       = c.c_out;
  assign CONin      = c.con_in;
  assign OUT_portin = c.out_portin;
  assign IN_portout = c.in_portout;
  assign ALUControl = c.alu;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed literal checks plus randomized instruction stream
// compared every cycle against a table-driven step model.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        GlobalReset, CONout, Stop;
  logic [31:0] IR;
  logic Run, PCout, PCin, PCinc, MARin, MDRin, MDRout, Read, write;
  logic IRin, Yin, Zin, Zhiout, Zloout, HIin, HIout, LOin, LOout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, OUT_portin, IN_portout;
  logic [4:0] ALUControl;

  always #5 Clock = ~Clock;

  control_unit dut (
    .Clock(Clock), .GlobalReset(GlobalReset), .IR(IR), .CONout(CONout), .Stop(Stop),
    .Run(Run), .PCout(PCout), .PCin(PCin), .PCinc(PCinc),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .write(write),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zhiout(Zhiout), .Zloout(Zloout),
    .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .CONin(CONin), .OUT_portin(OUT_portin), .IN_portout(IN_portout),
    .ALUControl(ALUControl)
  );

  // Bit i of the output word is one control line; ALUControl sits in [32:28].
  logic [32:0] dut_w;
  assign dut_w = {ALUControl, IN_portout, OUT_portin, CONin, Cout, BAout, Rout, Rin, Grc, Grb, Gra,
                  LOout, LOin, HIout, HIin, Zloout, Zhiout, Zin, Yin, IRin,
                  write, Read, MDRout, MDRin, MARin, PCinc, PCin, PCout, Run};

  localparam logic [32:0] RUN = 33'h1 << 0,  PCO = 33'h1 << 1,  PCI = 33'h1 << 2,  PCN = 33'h1 << 3;
  localparam logic [32:0] MAR = 33'h1 << 4,  MDI = 33'h1 << 5,  MDO = 33'h1 << 6,  RD  = 33'h1 << 7;
  localparam logic [32:0] WR  = 33'h1 << 8,  IRI = 33'h1 << 9,  YI  = 33'h1 << 10, ZI  = 33'h1 << 11;
  localparam logic [32:0] ZLO = 33'h1 << 13, HIO = 33'h1 << 15, LOO = 33'h1 << 17;
  localparam logic [32:0] GA  = 33'h1 << 18, GB  = 33'h1 << 19, GC  = 33'h1 << 20, RI  = 33'h1 << 21;
  localparam logic [32:0] RO  = 33'h1 << 22, BA  = 33'h1 << 23, CO  = 33'h1 << 24, CNI = 33'h1 << 25;
  localparam logic [32:0] OPI = 33'h1 << 26, IPO = 33'h1 << 27;
  localparam logic [32:0] ADD3 = 33'd3 << 28;
  localparam logic [32:0] T0W = RUN | PCO | MAR | PCN;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model: mode 0 = reset, 1 = running (k = step index from T0), 2 = halted.
  int m_mode = 0;
  int m_k = 0;

  function automatic int lat(input logic [4:0] op);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd1: lat = 6;
      5'd0, 5'd2:                          lat = 8;
      5'd18:                               lat = 7;
      5'd20:                               lat = 5;
      default:                             lat = 4;
    endcase
  endfunction

  function automatic logic [32:0] exec_w(input logic [4:0] op, input int s, input logic con);
    logic [32:0] w;
    w = '0;
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6:
        case (s) 0: w = GB|RO|YI; 1: w = GC|RO|ZI | ({28'd0, op} << 28); 2: w = ZLO|GA|RI; default: ; endcase
      5'd12, 5'd1:
        case (s) 0: w = GB|YI|(op == 5'd12 ? RO : BA); 1: w = CO|ZI|ADD3; 2: w = ZLO|GA|RI; default: ; endcase
      5'd0, 5'd2:
        case (s)
          0: w = GB|BA|YI;
          1: w = CO|ZI|ADD3;
          2: w = ZLO|MAR;
          3: w = (op == 5'd0) ? (RD|MDI) : (GA|RO|MDI);
          4: w = (op == 5'd0) ? (MDO|GA|RI) : WR;
          default: ;
        endcase
      5'd18:
        case (s) 0: w = GA|RO|CNI; 1: w = PCO|YI; 2: w = CO|ZI|ADD3; 3: w = con ? (ZLO|PCI) : '0; default: ; endcase
      5'd19: if (s == 0) w = GA|RO|PCI;
      5'd20: case (s) 0: w = PCO|GB|RI; 1: w = GA|RO|PCI; default: ; endcase
      5'd21: if (s == 0) w = IPO|GA|RI;
      5'd22: if (s == 0) w = GA|RO|OPI;
      5'd23: if (s == 0) w = HIO|GA|RI;
      5'd24: if (s == 0) w = LOO|GA|RI;
      default: ;
    endcase
    exec_w = w;
  endfunction

  function automatic logic [32:0] exp_w(input int mode, input int k, input logic [4:0] op, input logic con);
    if (mode != 1)   exp_w = '0;
    else if (k == 0) exp_w = T0W;
    else if (k == 1) exp_w = RUN | RD | MDI;
    else if (k == 2) exp_w = RUN | MDO | IRI;
    else             exp_w = RUN | exec_w(op, k - 3, con);
  endfunction

  always @(posedge Clock) begin
    if (GlobalReset) m_mode <= 0;
    else if (m_mode == 0) begin m_mode <= 1; m_k <= 0; end
    else if (m_mode == 1) begin
      if (m_k == 3 && IR[31:27] == 5'd26) m_mode <= 2;
      else if (m_k >= lat(IR[31:27]) - 1) begin
        if (Stop) m_mode <= 2;
        else      m_k <= 0;
      end else m_k <= m_k + 1;
    end
  end

  always @(negedge Clock) begin : cmp
    logic [32:0] e;
    if (chk_en) begin
      e = exp_w(m_mode, m_k, IR[31:27], CONout);
      vectors++;
      if (dut_w !== e) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t mode=%0d step=%0d op=%0d got=%h exp=%h",
                 $time, m_mode, m_k, IR[31:27], dut_w, e);
      end
    end
  end

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic skip(input int n);
    repeat (n) tick();
  endtask

  task automatic lit(input string name, input logic [32:0] exp);
    @(negedge Clock);
    vectors++;
    if (dut_w !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", name, dut_w, exp);
    end
    tick();
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op);
    logic [26:0] lo;
    lo = 27'($urandom);
    mk_ir = {op, lo};
  endfunction

  logic [4:0] valid_ops [17] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd18,
                                 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26};

  function automatic logic [4:0] pick_op();
    if ($urandom_range(0, 19) < 17) pick_op = valid_ops[$urandom_range(0, 16)];
    else                            pick_op = 5'($urandom_range(0, 31));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    GlobalReset = 1'b1; Stop = 1'b0; CONout = 1'b0; IR = mk_ir(5'd3);
    tick();
    chk_en = 1'b1;
    lit("reset", '0);
    GlobalReset = 1'b0;
    lit("reset_hold", '0);

    // add: 6-cycle instruction, T0 again on the 7th cycle
    lit("add_t0", T0W);
    skip(3);
    lit("add_t4", RUN|GC|RO|ZI|ADD3);
    lit("add_t5", RUN|ZLO|GA|RI);
    lit("add_next_t0", T0W);

    IR = mk_ir(5'd0);
    lit("ld_t1", RUN|RD|MDI);
    skip(4);
    lit("ld_t6", RUN|RD|MDI);
    lit("ld_t7", RUN|MDO|GA|RI);
    lit("ld_next_t0", T0W);

    IR = mk_ir(5'd18); CONout = 1'b0;
    skip(4);
    lit("br_c0_t5", RUN|CO|ZI|ADD3);
    lit("br_c0_t6", RUN);
    lit("br_c0_next", T0W);
    CONout = 1'b1;
    skip(5);
    lit("br_c1_t6", RUN|ZLO|PCI);
    lit("br_c1_next", T0W);

    IR = mk_ir(5'd19);
    skip(2);
    lit("jr_t3", RUN|GA|RO|PCI);
    lit("jr_next", T0W);

    IR = mk_ir(5'd26);
    skip(2);
    lit("halt_t3", RUN);
    lit("halted", '0);
    lit("halted2", '0);
    GlobalReset = 1'b1;
    lit("rst_in_halt", '0);
    GlobalReset = 1'b0;
    lit("rst_state", '0);

    IR = mk_ir(5'd3);
    skip(5);
    Stop = 1'b1;
    lit("add_t5_stop", RUN|ZLO|GA|RI);
    Stop = 1'b0;
    lit("stop_halt", '0);
    lit("stop_halt2", '0);
    GlobalReset = 1'b1; skip(1);
    GlobalReset = 1'b0; skip(1);

    IR = mk_ir(5'd0);
    skip(5);
    GlobalReset = 1'b1;
    lit("ld_t5_pre", RUN|ZLO|MAR);
    GlobalReset = 1'b0;
    lit("post_rst", '0);
    lit("post_rst_t0", T0W);

    repeat (3000) begin
      CONout = 1'($urandom_range(0, 1));
      Stop   = ($urandom_range(0, 11) == 0);
      if (m_mode == 2) GlobalReset = ($urandom_range(0, 3) == 0);
      else             GlobalReset = ($urandom_range(0, 149) == 0);
      if (m_mode == 1 && m_k == 0) IR = mk_ir(pick_op());
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL: Clock  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL: GlobalReset  input  1  synchronous, active-high reset.
REQ-003 SHALL: IR  input  32  current instruction; opcode is IR[31:27].
REQ-004 SHALL: CONout  input  1  branch condition from CON FF logic.
REQ-005 SHALL: Stop  input  1  halt request, honoured at instruction boundary.
REQ-006 SHALL: Run  output  1  high while fetching/executing, low in RESET and HALT.
REQ-007 SHALL: PCout, PCin, PCinc  output  1 each  PC bus drive, load, increment.
REQ-008 SHALL: MARin, MDRin, MDRout, Read, write  output  1 each  memory interface.
REQ-009 SHALL: IRin, Yin, Zin, Zhiout, Zloout  output  1 each  IR/Y/Z controls.
REQ-010 SHALL: HIin, HIout, LOin, LOout  output  1 each  HI/LO controls.
REQ-011 SHALL: Gra, Grb, Grc, Rin, Rout, BAout, Cout  output  1 each  select-encode and immediate controls.
REQ-012 SHALL: CONin, OUT_portin, IN_portout  output  1 each  CON latch and I/O ports.
REQ-013 SHALL: ALUControl  output  5  ALU operation; 0 when unused.

Function
REQ-014 SHALL: Moore controller; outputs decode only registered state, IR and CONout; each step lasts exactly one clock.
REQ-015 SHALL: states RESET, T0..T7, HALT; unlisted outputs are 0 in every step.
REQ-016 SHALL: fetch T0 PCout MARin PCinc; T1 Read MDRin; T2 MDRout IRin; T3 onward decode IR[31:27].
REQ-017 SHALL: opcodes ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, br 10010, jr 10011, jal 10100, in 10101, out 10110, mfhi 10111, mflo 11000, nop 11001, halt 11010; every other code executes as nop.
REQ-018 SHALL: add/sub/and/or: T3 Grb Rout Yin; T4 Grc Rout Zin, ALUControl=opcode; T5 Zloout Gra Rin.
REQ-019 SHALL: addi/ldi: T3 Grb Yin plus Rout (addi) or BAout (ldi); T4 Cout Zin ALUControl=00011; T5 Zloout Gra Rin.
REQ-020 SHALL: ld: T3 Grb BAout Yin; T4 Cout Zin ALU=00011; T5 Zloout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
REQ-021 SHALL: st: T3–T5 as ld; T6 Gra Rout MDRin (Read=0); T7 write.
REQ-022 SHALL: br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin ALU=00011; T6 Zloout PCin only if CONout=1, else nothing.
REQ-023 SHALL: jr T3 Gra Rout PCin; jal T3 PCout Grb Rin, T4 Gra Rout PCin.
REQ-024 SHALL: in T3 IN_portout Gra Rin; out T3 Gra Rout OUT_portin; mfhi/mflo T3 HIout/LOout Gra Rin; nop T3 empty.
REQ-025 SHALL: after an instruction's final step, next state is T0, or HALT if Stop=1 on that cycle.
REQ-026 SHALL: halt opcode at T3 transitions to HALT; HALT holds all outputs 0 and Run=0 until GlobalReset.
REQ-027 SHALL: latencies (T0 to final step inclusive): jr/in/out/mfhi/mflo/nop 4, jal 5, ALU/imm 6, br 7, ld/st 8 cycles.

Reset
REQ-028 SHALL: GlobalReset=1 at a rising edge forces RESET regardless of state, including mid-instruction and HALT; no partial step completes.
REQ-029 SHALL: in RESET all outputs 0, ALUControl=0, Run=0; first edge with GlobalReset=0 moves to T0.

Structure
REQ-030 SHALL: opcode constants, ALU codes (ADD 00011, SUB 00100, AND 00101, OR 00110) and state encodings live in shared package cpu_pkg.
REQ-031 SHALL: one sub-module cu_decode maps IR[31:27] to instruction class; state register and output decode stay in control_unit.

Verification
REQ-032 SHALL: reset, IR[31:27]=00011 -> T0 PCout/MARin/PCinc, T4 Grc Rout Zin ALU=00011, T5 Zloout Gra Rin, T0 on 7th cycle.
REQ-033 SHALL: ld -> Read high exactly in T1 and T6, MDRout+Gra+Rin in T7, 8-cycle instruction.
REQ-034 SHALL: br with CONout=0 then 1 -> PCin never asserted, then asserted exactly one cycle in T6.
REQ-035 SHALL: jr -> single T3 cycle with Gra Rout PCin, T0 next.
REQ-036 SHALL: halt opcode, and separately Stop=1 during add T5 -> Run falls, all outputs 0 until GlobalReset.
REQ-037 SHALL: GlobalReset pulsed during ld T5 -> all outputs 0 next cycle, T0 after release, MARin never seen with Zloout post-reset.
